// File: rtl/fwrisc_operand_fetch.sv
// fwrisc_operand_fetch: register-file operand fetch stage ahead of execute.
// Define FWRISC_OPFETCH_BYPASS_EN to forward writeback data into fetched operands.
module fwrisc_operand_fetch #(
    parameter int TAG_W  = 32,
    parameter int REG_AW = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [REG_AW-1:0] ra_raddr,
    input  logic [31:0]       ra_rdata,
    output logic [REG_AW-1:0] rb_raddr,
    input  logic [31:0]       rb_rdata,
    input  logic [REG_AW-1:0] rd_waddr,
    input  logic [31:0]       rd_wdata,
    input  logic              rd_wen,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_op_a,
    output logic [31:0]       out_op_b,
    output logic [REG_AW-1:0] out_rs1,
    output logic [REG_AW-1:0] out_rs2,
    output logic [TAG_W-1:0]  out_tag
);
    typedef enum logic [1:0] {
        IDLE,
        READ,
        HOLD
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        hit_a;
    logic        hit_b;
    logic [31:0] op_a_nxt;
    logic [31:0] op_b_nxt;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = READ;
            READ:    state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = in_valid ? READ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
        out_valid = (state == HOLD);
    end

    assign accept   = in_valid && in_ready;
    assign ra_raddr = accept ? in_rs1 : out_rs1;
    assign rb_raddr = accept ? in_rs2 : out_rs2;

`ifdef FWRISC_OPFETCH_BYPASS_EN
    assign hit_a = rd_wen && (rd_waddr == out_rs1);
    assign hit_b = rd_wen && (rd_waddr == out_rs2);
`else
    logic unused_wb;
    assign unused_wb = ^{rd_wen, rd_waddr, rd_wdata};
    assign hit_a     = 1'b0;
    assign hit_b     = 1'b0;
`endif

    always_comb begin
        op_a_nxt = out_op_a;
        op_b_nxt = out_op_b;
        unique case (state)
            READ: begin
                op_a_nxt = hit_a ? rd_wdata : ra_rdata;
                op_b_nxt = hit_b ? rd_wdata : rb_rdata;
            end
            HOLD: begin
                if (hit_a) op_a_nxt = rd_wdata;
                if (hit_b) op_b_nxt = rd_wdata;
            end
            default: ;
        endcase
        // x0 is hard zero whatever the file or writeback bus carries
        if (state != IDLE) begin
            if (out_rs1 == '0) op_a_nxt = '0;
            if (out_rs2 == '0) op_b_nxt = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_op_a <= '0;
            out_op_b <= '0;
            out_rs1  <= '0;
            out_rs2  <= '0;
            out_tag  <= '0;
        end else begin
            out_op_a <= op_a_nxt;
            out_op_b <= op_b_nxt;
            if (accept) begin
                out_rs1 <= in_rs1;
                out_rs2 <= in_rs2;
                out_tag <= in_tag;
            end
        end
    end
endmodule

// File: tb/tb_fwrisc_operand_fetch.sv
// tb_fwrisc_operand_fetch: randomized self-checking bench for the operand fetch stage.
// A registered-address register file model sits behind the read ports.
module tb_fwrisc_operand_fetch;
    localparam int TAG_W  = 32;
    localparam int REG_AW = 6;
`ifdef FWRISC_OPFETCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [REG_AW-1:0] in_rs1 = '0;
    logic [REG_AW-1:0] in_rs2 = '0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic [REG_AW-1:0] ra_raddr;
    logic [31:0]       ra_rdata;
    logic [REG_AW-1:0] rb_raddr;
    logic [31:0]       rb_rdata;
    logic [REG_AW-1:0] rd_waddr = '0;
    logic [31:0]       rd_wdata = '0;
    logic              rd_wen = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [31:0]       out_op_a;
    logic [31:0]       out_op_b;
    logic [REG_AW-1:0] out_rs1;
    logic [REG_AW-1:0] out_rs2;
    logic [TAG_W-1:0]  out_tag;

    int vectors = 0;
    int errors  = 0;

    fwrisc_operand_fetch #(.TAG_W(TAG_W), .REG_AW(REG_AW)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .ra_raddr(ra_raddr), .ra_rdata(ra_rdata),
        .rb_raddr(rb_raddr), .rb_rdata(rb_rdata),
        .rd_waddr(rd_waddr), .rd_wdata(rd_wdata), .rd_wen(rd_wen),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op_a(out_op_a), .out_op_b(out_op_b),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_tag(out_tag)
    );

    always #5 clock = ~clock;

    // register file: address registered, data read from the array the next cycle
    logic [31:0]       mem [64];
    logic [REG_AW-1:0] ra_q = '0;
    logic [REG_AW-1:0] rb_q = '0;
    always @(posedge clock) begin
        ra_q <= ra_raddr;
        rb_q <= rb_raddr;
        if (rd_wen) mem[rd_waddr] <= rd_wdata;
    end
    assign ra_rdata = mem[ra_q];
    assign rb_rdata = mem[rb_q];

    function automatic logic [31:0] arch(input logic [REG_AW-1:0] a);
        return (a == '0) ? 32'h0 : mem[a];
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic wb_write(input logic [REG_AW-1:0] a, input logic [31:0] d);
        rd_wen = 1'b1; rd_waddr = a; rd_wdata = d;
        cyc();
        rd_wen = 1'b0;
    endtask

    task automatic issue(input logic [REG_AW-1:0] r1, input logic [REG_AW-1:0] r2, input logic [31:0] t);
        in_valid = 1'b1; in_rs1 = r1; in_rs2 = r2; in_tag = t;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 64; i++) begin
            rd_wen = 1'b1; rd_waddr = 6'(i); rd_wdata = $urandom;
            cyc();
        end
        rd_wen = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", in_ready); end
        vectors++; if (out_op_a !== 32'h0 || out_op_b !== 32'h0) begin errors++; $display("FAIL reset_ops: got %h %h want 0 0", out_op_a, out_op_b); end
        vectors++; if (out_tag !== '0 || out_rs1 !== '0 || out_rs2 !== '0) begin errors++; $display("FAIL reset_tag: got %h %0d %0d want 0", out_tag, out_rs1, out_rs2); end
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        logic [31:0] t;
        t = $urandom;
        wb_write(5, 32'h1234);
        wb_write(6, 32'hABCD);
        out_ready = 1'b1;
        issue(5, 6, t);
        #1;
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_accept: got %0b want 1", in_ready); end
        vectors++; if (ra_raddr !== 6'd5 || rb_raddr !== 6'd6) begin errors++; $display("FAIL basic_raddr: got %0d %0d want 5 6", ra_raddr, rb_raddr); end
        cyc();
        in_valid = 1'b0; in_rs1 = 6'd33; in_rs2 = 6'd34;
        #1;
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL basic_read: got v=%0b r=%0b want 0 0", out_valid, in_ready); end
        vectors++; if (ra_raddr !== 6'd5 || rb_raddr !== 6'd6) begin errors++; $display("FAIL basic_hold_addr: got %0d %0d want 5 6", ra_raddr, rb_raddr); end
        cyc();
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b want 1", out_valid); end
        vectors++; if (out_op_a !== 32'h1234 || out_op_b !== 32'hABCD) begin errors++; $display("FAIL basic_ops: got %h %h want 1234 abcd", out_op_a, out_op_b); end
        vectors++; if (out_tag !== t || out_rs1 !== 6'd5 || out_rs2 !== 6'd6) begin errors++; $display("FAIL basic_tag: got %h %0d %0d want %h 5 6", out_tag, out_rs1, out_rs2, t); end
        cyc();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %0b want 0", out_valid); end
    endtask

    task automatic test_read_fwd();
        logic [31:0] old7;
        wb_write(7, $urandom);
        wb_write(0, 32'hBAD0BAD0);
        old7 = mem[7];
        issue(7, 0, 32'h77770007);
        cyc();
        in_valid = 1'b0;
        rd_wen = 1'b1; rd_waddr = 7; rd_wdata = 32'hDEADBEEF;
        cyc();
        rd_wen = 1'b0;
        vectors++; if (out_op_a !== (BYPASS ? 32'hDEADBEEF : old7)) begin errors++; $display("FAIL fwd_op_a: got %h want %h", out_op_a, BYPASS ? 32'hDEADBEEF : old7); end
        vectors++; if (out_op_b !== 32'h0) begin errors++; $display("FAIL fwd_x0: got %h want 0", out_op_b); end
        cyc();
    endtask

    task automatic test_hold_refresh();
        logic [31:0] r10;
        r10 = $urandom;
        wb_write(9, 32'h1);
        wb_write(10, r10);
        out_ready = 1'b0;
        issue(9, 10, 32'h99);
        cyc();
        in_valid = 1'b0;
        cyc();
        vectors++; if (out_op_a !== 32'h1 || out_op_b !== r10) begin errors++; $display("FAIL hold_ops: got %h %h want 1 %h", out_op_a, out_op_b, r10); end
        rd_wen = 1'b1; rd_waddr = 9; rd_wdata = 32'h55;
        issue(11, 12, 32'h1111);
        cyc();
        rd_wen = 1'b0;
        vectors++; if (out_op_a !== (BYPASS ? 32'h55 : 32'h1)) begin errors++; $display("FAIL hold_refresh: got %h want %h", out_op_a, BYPASS ? 32'h55 : 32'h1); end
        vectors++; if (out_op_b !== r10) begin errors++; $display("FAIL hold_op_b: got %h want %h", out_op_b, r10); end
        vectors++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL hold_stall: got v=%0b r=%0b want 1 0", out_valid, in_ready); end
        vectors++; if (out_tag !== 32'h99 || out_rs1 !== 6'd9) begin errors++; $display("FAIL hold_tag: got %h %0d want 99 9", out_tag, out_rs1); end
        in_valid = 1'b0;
        cyc();
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_keep: got %0b want 1", out_valid); end
        out_ready = 1'b1;
        cyc();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release: got %0b want 0", out_valid); end
    endtask

    task automatic test_same_reg();
        logic [31:0] old3;
        logic [31:0] r12;
        wb_write(3, $urandom);
        old3 = mem[3];
        issue(3, 3, 32'h3);
        cyc();
        in_valid = 1'b0;
        rd_wen = 1'b1; rd_waddr = 3; rd_wdata = 32'h77;
        cyc();
        rd_wen = 1'b0;
        vectors++; if (out_op_a !== (BYPASS ? 32'h77 : old3) || out_op_b !== (BYPASS ? 32'h77 : old3)) begin errors++; $display("FAIL same_reg: got %h %h want %h", out_op_a, out_op_b, BYPASS ? 32'h77 : old3); end
        cyc();
        wb_write(12, $urandom);
        r12 = mem[12];
        issue(0, 12, 32'h0C);
        cyc();
        in_valid = 1'b0;
        rd_wen = 1'b1; rd_waddr = 0; rd_wdata = 32'hFF;
        cyc();
        rd_wen = 1'b0;
        vectors++; if (out_op_a !== 32'h0) begin errors++; $display("FAIL x0_write: got %h want 0", out_op_a); end
        vectors++; if (out_op_b !== r12) begin errors++; $display("FAIL x0_other: got %h want %h", out_op_b, r12); end
        cyc();
    endtask

    task automatic test_back_to_back();
        localparam int K = 12;
        logic [REG_AW-1:0] rs1a [K];
        logic [REG_AW-1:0] rs2a [K];
        logic [31:0]       tags [K];
        logic [31:0]       snap_a [K];
        logic [31:0]       snap_b [K];
        for (int k = 0; k < K; k++) begin
            rs1a[k] = 6'($urandom_range(0, 63));
            rs2a[k] = 6'($urandom_range(0, 63));
            tags[k] = $urandom;
        end
        out_ready = 1'b1;
        for (int c = 0; c <= 2 * K; c++) begin
            int idx;
            int jj;
            int sel;
            idx = (c + 1) / 2;
            jj  = (c / 2 < K) ? c / 2 : K - 1;
            if (idx < K) issue(rs1a[idx], rs2a[idx], tags[idx]);
            else in_valid = 1'b0;
            sel = $urandom_range(0, 2);
            rd_wen   = ($urandom_range(0, 1) == 1);
            rd_wdata = $urandom;
            rd_waddr = (sel == 0) ? rs1a[jj] : (sel == 1) ? rs2a[jj] : 6'($urandom_range(0, 63));
            #1;
            vectors++; if (in_ready !== (c % 2 == 0)) begin errors++; $display("FAIL b2b_ready c=%0d: got %0b want %0b", c, in_ready, c % 2 == 0); end
            vectors++; if (out_valid !== (c >= 2 && c % 2 == 0)) begin errors++; $display("FAIL b2b_valid c=%0d: got %0b want %0b", c, out_valid, c >= 2 && c % 2 == 0); end
            if (c % 2 == 1) begin
                snap_a[c / 2] = arch(rs1a[c / 2]);
                snap_b[c / 2] = arch(rs2a[c / 2]);
            end
            if (c >= 2 && c % 2 == 0) begin
                int j;
                logic [31:0] ea;
                logic [31:0] eb;
                j  = (c - 2) / 2;
                ea = BYPASS ? arch(rs1a[j]) : snap_a[j];
                eb = BYPASS ? arch(rs2a[j]) : snap_b[j];
                vectors++; if (out_tag !== tags[j]) begin errors++; $display("FAIL b2b_tag j=%0d: got %h want %h", j, out_tag, tags[j]); end
                vectors++; if (out_op_a !== ea || out_op_b !== eb) begin errors++; $display("FAIL b2b_ops j=%0d: got %h %h want %h %h", j, out_op_a, out_op_b, ea, eb); end
            end
            cyc();
        end
        in_valid = 1'b0;
        rd_wen = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %0b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] t;
        issue(5, 6, 32'hAAAA);
        cyc();
        in_valid = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_read_hs: got v=%0b r=%0b want 0 1", out_valid, in_ready); end
        vectors++; if (out_op_a !== 32'h0 || out_op_b !== 32'h0 || out_tag !== '0) begin errors++; $display("FAIL rst_read_out: got %h %h %h want 0", out_op_a, out_op_b, out_tag); end
        cyc();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_read_drop: got %0b want 0", out_valid); end
        out_ready = 1'b0;
        issue(6, 5, 32'hBBBB);
        cyc();
        in_valid = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        out_ready = 1'b1;
        vectors++; if (out_valid !== 1'b0 || out_op_a !== 32'h0) begin errors++; $display("FAIL rst_hold: got v=%0b a=%h want 0 0", out_valid, out_op_a); end
        t = $urandom;
        issue(6, 5, t);
        cyc();
        in_valid = 1'b0;
        cyc();
        vectors++; if (out_valid !== 1'b1 || out_tag !== t) begin errors++; $display("FAIL rst_next: got v=%0b tag=%h want 1 %h", out_valid, out_tag, t); end
        vectors++; if (out_op_a !== arch(6) || out_op_b !== arch(5)) begin errors++; $display("FAIL rst_next_ops: got %h %h want %h %h", out_op_a, out_op_b, arch(6), arch(5)); end
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_read_fwd();
        test_hold_refresh();
        test_same_reg();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
